btn_conditioner: RTL and testbench
==================================

BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 The block SHALL have the parameter ACTIVE_LOW, default 1; 1 means the raw button reads 0 when pressed.
REQ-002 The block SHALL have the parameter DEBOUNCE_BITS, default 16; the debounce window is 2^DEBOUNCE_BITS consecutive disagreeing cycles.
REQ-003 The block SHALL have the parameter HOLD_CYCLES, default 50_000_000; it is the press-to-long-press distance in cycles, minimum 2.
REQ-004 The block SHALL have the parameter REPEAT_CYCLES, default 10_000_000; it is the auto-repeat period in cycles, minimum 2.
REQ-005 The block SHALL have the port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have the port button, input, 1 bit: raw asynchronous pushbutton pin.
REQ-008 The block SHALL have the port pressed, output, 1 bit: debounced level, 1 = held.
REQ-009 The block SHALL have the ports press_pulse and release_pulse, output, 1 bit each: one-cycle strobes on debounced edges.
REQ-010 The block SHALL have the ports long_pulse and repeat_pulse, output, 1 bit each: one-cycle hold and auto-repeat strobes.
REQ-011 The block SHALL have the port step, output, 1 bit: press_pulse OR long_pulse OR repeat_pulse, the advance strobe for the downstream LED/state FSM.

Function
REQ-012 The raw button SHALL pass through a two-flop synchronizer, inverted first when ACTIVE_LOW=1, giving sync (1 = pressed).
REQ-013 The DEBOUNCE_BITS-wide counter SHALL clear on any cycle where sync equals pressed, and increment otherwise.
REQ-014 When sync differs from pressed and the counter is all-ones, pressed SHALL toggle and the counter SHALL wrap to 0 on that edge.
REQ-015 Debounce latency: with edge k the first edge sampling a stable new button level, pressed SHALL change at edge k+2^DEBOUNCE_BITS+1.
REQ-016 A raw disturbance shorter than 2^DEBOUNCE_BITS synchronized cycles SHALL produce no change on any output.
REQ-017 The FSM SHALL have three states: IDLE (pressed=0), DOWN (held, hold count running) and REPEAT (held, repeat count running).
REQ-018 Transition IDLE->DOWN: on the edge pressed rises, press_pulse SHALL be 1 for the following cycle and the cycle counter SHALL clear.
REQ-019 In DOWN, if press_pulse was high in cycle t, long_pulse SHALL be high in cycle t+HOLD_CYCLES only; the FSM SHALL enter REPEAT and the counter SHALL clear.
REQ-020 In REPEAT, repeat_pulse SHALL be high in cycles t+HOLD_CYCLES+j*REPEAT_CYCLES for j>=1, and the counter SHALL wrap after each pulse.
REQ-021 Transition DOWN/REPEAT->IDLE: on the edge pressed falls, release_pulse SHALL be 1 for the following cycle and the counter SHALL clear.
REQ-022 Simultaneous events: if pressed falls on the edge a long or repeat pulse would fire, release SHALL win and no long or repeat pulse SHALL occur.
REQ-023 At most one of press_pulse, release_pulse, long_pulse and repeat_pulse SHALL be high in any cycle.
REQ-024 The hold/repeat counter SHALL be wide enough for max(HOLD_CYCLES, REPEAT_CYCLES)-1 and SHALL never wrap silently.
REQ-025 All outputs SHALL be registered, with no combinational path from button to any output.

Reset
REQ-026 While rst=1 at an edge, the synchronizer flops SHALL load the released level, all counters 0, state IDLE, and every output 0.
REQ-027 Reset mid-press: if button is still held after rst deasserts, press_pulse SHALL fire again after a full debounce latency (REQ-015); no release_pulse SHALL be emitted for the aborted press.

Structure
REQ-028 Package btn_pkg SHALL hold the FSM state typedef (IDLE, DOWN, REPEAT) and the default timing constants.
REQ-029 Sub-module btn_sync_debounce SHALL contain the synchronizer and debounce counter (REQ-012..016) and output pressed plus rise/fall strobes; the top holds the FSM and the hold/repeat counter.

Verification (all with DEBOUNCE_BITS=3, HOLD_CYCLES=20, REPEAT_CYCLES=5, ACTIVE_LOW=1)
REQ-030 Press: button driven 0 at edge k and held -> press_pulse and step high for exactly the cycle after edge k+9, and pressed=1 from then on.
REQ-031 Glitch: button 0 for 7 cycles then 1 -> all outputs stay 0.
REQ-032 Hold 40 cycles after press_pulse at cycle t -> long_pulse at t+20, repeat_pulse at t+25, t+30, t+35 and t+40, then release_pulse 10 cycles after button returns to 1.
REQ-033 Race: button released so that pressed falls on the edge for t+20 -> release_pulse only, and long_pulse never asserts.
REQ-034 Reset: rst pulsed at t+12 with button held -> all outputs 0 immediately; press_pulse recurs 10 cycles after rst deasserts; no release_pulse is seen.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared definitions for the pushbutton conditioner: FSM state encoding,
// default timing constants and a small sizing helper.
package btn_pkg;

    typedef logic [1:0] btn_state_t;

    localparam btn_state_t IDLE   = 2'd0;
    localparam btn_state_t DOWN   = 2'd1;
    localparam btn_state_t REPEAT = 2'd2;

    localparam int DEF_ACTIVE_LOW    = 1;
    localparam int DEF_DEBOUNCE_BITS = 16;
    localparam int DEF_HOLD_CYCLES   = 50_000_000;
    localparam int DEF_REPEAT_CYCLES = 10_000_000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_sync_debounce.sv
// Two-flop synchronizer plus saturating-window debouncer; emits the debounced
// level and combinational rise/fall strobes announcing the coming toggle.
module btn_sync_debounce
    import btn_pkg::*;
#(
    parameter int ACTIVE_LOW    = DEF_ACTIVE_LOW,
    parameter int DEBOUNCE_BITS = DEF_DEBOUNCE_BITS
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic pressed,
    output logic rise,
    output logic fall
);

    logic                     raw_s;
    logic                     meta_r;
    logic                     sync_r;
    logic                     pressed_r;
    logic [DEBOUNCE_BITS-1:0] db_cnt_r;
    logic                     flip_s;

    assign raw_s  = (ACTIVE_LOW != 0) ? ~button : button;
    // Toggle only when the window has fully elapsed with sync still disagreeing.
    assign flip_s = (sync_r != pressed_r) && (&db_cnt_r);

    // Synchronizer, debounce counter and debounced level.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r    <= 1'b0;
            sync_r    <= 1'b0;
            pressed_r <= 1'b0;
            db_cnt_r  <= '0;
        end else begin
            meta_r <= raw_s;
            sync_r <= meta_r;
            if (sync_r == pressed_r) begin
                db_cnt_r <= '0;
            end else begin
                db_cnt_r <= db_cnt_r + DEBOUNCE_BITS'(1);
            end
            if (flip_s) begin
                pressed_r <= ~pressed_r;
            end else begin
                pressed_r <= pressed_r;
            end
        end
    end

    assign pressed = pressed_r;
    assign rise    = flip_s & ~pressed_r;
    assign fall    = flip_s & pressed_r;

endmodule

// File: rtl/btn_conditioner.sv
// Pushbutton conditioner top: debounced level, press/release strobes and a
// hold/auto-repeat FSM producing long, repeat and combined step strobes.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int ACTIVE_LOW    = DEF_ACTIVE_LOW,
    parameter int DEBOUNCE_BITS = DEF_DEBOUNCE_BITS,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic step
);

    localparam int CNT_MAX = max_int(HOLD_CYCLES, REPEAT_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic             rise_s;
    logic             fall_s;
    btn_state_t       state_r;
    btn_state_t       state_nx_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nx_s;
    logic             press_nx_s;
    logic             release_nx_s;
    logic             long_nx_s;
    logic             repeat_nx_s;
    logic             press_r;
    logic             release_r;
    logic             long_r;
    logic             repeat_r;
    logic             step_r;

    btn_sync_debounce #(
        .ACTIVE_LOW    (ACTIVE_LOW),
        .DEBOUNCE_BITS (DEBOUNCE_BITS)
    ) u_sync_debounce (
        .clk     (clk),
        .rst     (rst),
        .button  (button),
        .pressed (pressed),
        .rise    (rise_s),
        .fall    (fall_s)
    );

    // Next-state logic; a falling debounced edge outranks any hold/repeat expiry.
    always_comb begin
        state_nx_s   = state_r;
        cnt_nx_s     = cnt_r;
        press_nx_s   = 1'b0;
        release_nx_s = 1'b0;
        long_nx_s    = 1'b0;
        repeat_nx_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (rise_s) begin
                    state_nx_s = DOWN;
                    press_nx_s = 1'b1;
                    cnt_nx_s   = '0;
                end else begin
                    cnt_nx_s   = '0;
                end
            end
            DOWN: begin
                if (fall_s) begin
                    state_nx_s   = IDLE;
                    release_nx_s = 1'b1;
                    cnt_nx_s     = '0;
                end else if (cnt_r == HOLD_LAST) begin
                    state_nx_s = REPEAT;
                    long_nx_s  = 1'b1;
                    cnt_nx_s   = '0;
                end else begin
                    cnt_nx_s   = cnt_r + CNT_W'(1);
                end
            end
            REPEAT: begin
                if (fall_s) begin
                    state_nx_s   = IDLE;
                    release_nx_s = 1'b1;
                    cnt_nx_s     = '0;
                end else if (cnt_r == REPEAT_LAST) begin
                    repeat_nx_s = 1'b1;
                    cnt_nx_s    = '0;
                end else begin
                    cnt_nx_s    = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nx_s = IDLE;
                cnt_nx_s   = '0;
            end
        endcase
    end

    // State, counter and registered strobe outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
            long_r    <= 1'b0;
            repeat_r  <= 1'b0;
            step_r    <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            cnt_r     <= cnt_nx_s;
            press_r   <= press_nx_s;
            release_r <= release_nx_s;
            long_r    <= long_nx_s;
            repeat_r  <= repeat_nx_s;
            step_r    <= press_nx_s | long_nx_s | repeat_nx_s;
        end
    end

    assign press_pulse   = press_r;
    assign release_pulse = release_r;
    assign long_pulse    = long_r;
    assign repeat_pulse  = repeat_r;
    assign step          = step_r;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: expected strobes are queued per clock
// edge when stimulus is applied and compared every cycle by a monitor.
module tb_btn_conditioner;

    logic clk = 1'b0;
    logic rst;
    logic button;
    logic pressed;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic step;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    // {press, release, long, repeat, step}
    localparam logic [4:0] V_NONE  = 5'b00000;
    localparam logic [4:0] V_PRESS = 5'b10001;
    localparam logic [4:0] V_REL   = 5'b01000;
    localparam logic [4:0] V_LONG  = 5'b00101;
    localparam logic [4:0] V_REP   = 5'b00011;

    typedef struct {
        int         edge_no;
        logic [4:0] vec;
        logic       pr;
    } exp_t;

    exp_t sb[$];
    logic cur_pr = 1'b0;

    btn_conditioner #(
        .ACTIVE_LOW    (1),
        .DEBOUNCE_BITS (3),
        .HOLD_CYCLES   (20),
        .REPEAT_CYCLES (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .button        (button),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse),
        .step          (step)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic push_exp(input int e, input logic [4:0] v, input logic p);
        exp_t x;
        x.edge_no = e;
        x.vec     = v;
        x.pr      = p;
        sb.push_back(x);
    endtask

    task automatic wait_until(input int target);
        while (edge_n < target) @(negedge clk);
    endtask

    // Monitor: outputs after edge n must equal the queued entry for n, else all strobes 0.
    always @(negedge clk) begin
        logic [4:0] exp_v;
        logic [4:0] got_v;
        exp_t       head;
        if (edge_n >= 1) begin
            exp_v = V_NONE;
            if (sb.size() > 0 && sb[0].edge_no == edge_n) begin
                head   = sb.pop_front();
                exp_v  = head.vec;
                cur_pr = head.pr;
            end
            got_v = {press_pulse, release_pulse, long_pulse, repeat_pulse, step};
            total++;
            assert (got_v === exp_v) else begin
                bad++;
                $error("FAIL strobes edge=%0d observed=%b expected=%b", edge_n, got_v, exp_v);
            end
            total++;
            assert (pressed === cur_pr) else begin
                bad++;
                $error("FAIL pressed edge=%0d observed=%b expected=%b", edge_n, pressed, cur_pr);
            end
        end
    end

    initial begin
        int e;
        rst    = 1'b1;
        button = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_until(edge_n + 5);

        // Glitch of exactly 7 sampled cycles: no output activity.
        button = 1'b0;
        repeat (7) @(negedge clk);
        button = 1'b1;
        wait_until(edge_n + 15);

        // Press, hold: long at t+20, repeats at t+25..t+40, release 10 cycles after letting go.
        e = edge_n + 1 + 9;
        button = 1'b0;
        push_exp(e, V_PRESS, 1'b1);
        push_exp(e + 20, V_LONG, 1'b1);
        push_exp(e + 25, V_REP, 1'b1);
        push_exp(e + 30, V_REP, 1'b1);
        push_exp(e + 35, V_REP, 1'b1);
        push_exp(e + 40, V_REP, 1'b1);
        push_exp(e + 41, V_REL, 1'b0);
        wait_until(e + 31);
        button = 1'b1;
        wait_until(e + 50);

        // Race: pressed falls on the edge the long pulse would fire.
        e = edge_n + 1 + 9;
        button = 1'b0;
        push_exp(e, V_PRESS, 1'b1);
        push_exp(e + 20, V_REL, 1'b0);
        wait_until(e + 10);
        button = 1'b1;
        wait_until(e + 30);

        // Reset mid-press: outputs clear, press recurs after full latency, no release.
        e = edge_n + 1 + 9;
        button = 1'b0;
        push_exp(e, V_PRESS, 1'b1);
        push_exp(e + 12, V_NONE, 1'b0);
        push_exp(e + 22, V_PRESS, 1'b1);
        push_exp(e + 34, V_REL, 1'b0);
        wait_until(e + 11);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_until(e + 24);
        button = 1'b1;
        wait_until(e + 45);

        @(posedge clk);
        #1;
        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
